ysyx_22050854_regfile_np: RTL and testbench

Parametrised multi-read-port integer register file for the ysyx_22050854 CPU core. It replaces the single-read-port register instance used for debug probing: N architectural read ports plus one independent debug read port, one write port, optional same-cycle write bypass, hardwired-zero x0, and a sequenced post-reset clear with an `init_done` handshake. It sits between decode (read addresses), writeback (write port) and the top-level debug/difftest taps.

---
 rtl/ysyx_22050854_regfile_np.sv | 122 ++++++++++++
 tb/tb_ysyx_22050854_regfile_np.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_regfile_np.sv
// Multi-read-port integer register file with hardwired-zero x0, optional write bypass,
// an independent debug read port, and a sequenced post-reset clear signalled by init_done.

module ysyx_22050854_regfile_np_rd #(
  parameter int XLEN   = 64,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            run,
  input  logic [AW-1:0]   raddr,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] arr,
  output logic [XLEN-1:0] rdata
);
  always_comb begin
    rdata = arr;
    if (!run || raddr == '0)
      rdata = '0;
    else if (BYPASS != 0 && wen && waddr == raddr)
      rdata = wdata;
  end
endmodule

module ysyx_22050854_regfile_np #(
  parameter  int XLEN   = 64,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wen,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_rdata,
  output logic                init_done
);
  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              init_done_q, init_done_d;
  logic [XLEN-1:0]   regs_q [NREG];

  logic              we_d;
  logic [AW-1:0]     wa_d;
  logic [XLEN-1:0]   wd_d;

  logic [NRD-1:0][AW-1:0]   ra;
  logic [NRD-1:0][XLEN-1:0] rd;

  assign ra        = raddr;
  assign rdata     = rd;
  assign init_done = init_done_q;

  // The array has a single write port shared by the clear sequencer and writeback.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    wa_d    = cnt_q;
    wd_d    = '0;
    if (rst) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end else if (state_q == CLEAR) begin
      we_d  = 1'b1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(NREG - 1)) state_d = RUN;
    end else if (wen && waddr != '0) begin
      we_d = 1'b1;
      wa_d = waddr;
      wd_d = wdata;
    end
    init_done_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we_d) regs_q[wa_d] <= wd_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    ysyx_22050854_regfile_np_rd #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rd (
      .run   (state_q == RUN),
      .raddr (ra[i]),
      .wen   (wen),
      .waddr (waddr),
      .wdata (wdata),
      .arr   (regs_q[ra[i]]),
      .rdata (rd[i])
    );
  end

  // Debug tap shows committed state only, so it never sees the bypass.
  ysyx_22050854_regfile_np_rd #(.XLEN(XLEN), .AW(AW), .BYPASS(0)) u_dbg (
    .run   (state_q == RUN),
    .raddr (dbg_addr),
    .wen   (1'b0),
    .waddr (waddr),
    .wdata (wdata),
    .arr   (regs_q[dbg_addr]),
    .rdata (dbg_rdata)
  );
endmodule

// File: tb/tb_ysyx_22050854_regfile_np.sv
// Bench for ysyx_22050854_regfile_np: default build (bypass on) plus a 32-bit/16-reg/3-port
// build with bypass off, both checked against a reference model through a scoreboard.

module tb_ysyx_22050854_regfile_np;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, wen0, done0;
  logic [4:0]  waddr0, dbg0;
  logic [63:0] wdata0, dbgd0;
  logic [9:0]  raddr0;
  logic [127:0] rdata0;

  logic        rst1, wen1, done1;
  logic [3:0]  waddr1, dbg1;
  logic [31:0] wdata1, dbgd1;
  logic [11:0] raddr1;
  logic [95:0] rdata1;

  ysyx_22050854_regfile_np u0 (
    .clk(clk), .rst(rst0), .wen(wen0), .waddr(waddr0), .wdata(wdata0),
    .raddr(raddr0), .rdata(rdata0), .dbg_addr(dbg0), .dbg_rdata(dbgd0), .init_done(done0)
  );

  ysyx_22050854_regfile_np #(.XLEN(32), .NREG(16), .NRD(3), .BYPASS(0)) u1 (
    .clk(clk), .rst(rst1), .wen(wen1), .waddr(waddr1), .wdata(wdata1),
    .raddr(raddr1), .rdata(rdata1), .dbg_addr(dbg1), .dbg_rdata(dbgd1), .init_done(done1)
  );

  int n_cmp = 0, n_err = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model
  bit          m_run [2];
  int          m_cnt [2];
  logic [63:0] m_reg [2][32];

  function automatic int nr(int k);   return k ? 16 : 32; endfunction
  function automatic int nrd(int k);  return k ? 3 : 2;   endfunction
  function automatic bit byp(int k);  return k ? 1'b0 : 1'b1; endfunction

  function automatic void m_upd(int k, logic r, logic w, int wa, logic [63:0] wd);
    if (r) begin
      m_run[k] = 1'b0;
      m_cnt[k] = 0;
    end else if (!m_run[k]) begin
      m_reg[k][m_cnt[k]] = '0;
      if (m_cnt[k] == nr(k) - 1) m_run[k] = 1'b1;
      m_cnt[k]++;
    end else if (w && wa != 0) begin
      m_reg[k][wa] = wd;
    end
  endfunction

  always @(posedge clk) begin
    m_upd(0, rst0, wen0, int'(waddr0), wdata0);
    m_upd(1, rst1, wen1, int'(waddr1), 64'(wdata1));
  end

  function automatic logic [63:0] m_rd(int k, int a, bit is_dbg);
    logic w; int wa; logic [63:0] wd;
    w  = k ? wen1 : wen0;
    wa = k ? int'(waddr1) : int'(waddr0);
    wd = k ? 64'(wdata1) : wdata0;
    if (!m_run[k] || a == 0) return '0;
    if (!is_dbg && byp(k) && w && wa == a) return wd;
    return m_reg[k][a];
  endfunction

  // Scoreboard
  typedef struct { string tag; logic [63:0] exp; } sb_t;
  sb_t sbq[$];

  function automatic void push(string t, logic [63:0] e);
    sb_t s;
    s.tag = t; s.exp = e;
    sbq.push_back(s);
  endfunction

  task automatic sb_cmp(string who, logic [63:0] obs);
    sb_t s;
    if (sbq.size() == 0) begin
      chk({who, "_sb_empty"}, obs, 64'hx);
      n_err += (obs === 64'hx) ? 1 : 0;
    end else begin
      s = sbq.pop_front();
      chk(s.tag, obs, s.exp);
    end
  endtask

  task automatic exp_all(int k);
    push($sformatf("k%0d_done", k), 64'(m_run[k]));
    for (int i = 0; i < nrd(k); i++)
      push($sformatf("k%0d_rd%0d", k, i),
           m_rd(k, k ? int'(raddr1[i*4 +: 4]) : int'(raddr0[i*5 +: 5]), 1'b0));
    push($sformatf("k%0d_dbg", k), m_rd(k, k ? int'(dbg1) : int'(dbg0), 1'b1));
  endtask

  task automatic cmp_all(int k);
    sb_cmp("done", k ? 64'(done1) : 64'(done0));
    for (int i = 0; i < nrd(k); i++)
      sb_cmp("rd", k ? 64'(rdata1[i*32 +: 32]) : rdata0[i*64 +: 64]);
    sb_cmp("dbg", k ? 64'(dbgd1) : dbgd0);
  endtask

  // Inputs are set at posedge+1; outputs are checked at the negedge, then the edge commits.
  task automatic step(int k);
    exp_all(k);
    @(negedge clk);
    cmp_all(k);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_wait(int k, int want);
    int n = 0;
    while (!(k ? done1 : done0) && n < 40) begin
      step(k);
      n++;
    end
    chk($sformatf("k%0d_clr_lat", k), 64'(n), 64'(want));
  endtask

  initial begin
    rst0 = 1'b1; wen0 = 1'b0; waddr0 = '0; wdata0 = '0; raddr0 = '0; dbg0 = '0;
    rst1 = 1'b1; wen1 = 1'b0; waddr1 = '0; wdata1 = '0; raddr1 = '0; dbg1 = '0;
    @(posedge clk); #1;
    step(0);

    // clear aborted at cycle 10, then a full clear
    rst0 = 1'b0;
    for (int i = 0; i < 10; i++) begin raddr0 = 10'($urandom); dbg0 = 5'(i); step(0); end
    rst0 = 1'b1; step(0);
    rst0 = 1'b0;
    clr_wait(0, 32);
    for (int a = 0; a < 32; a++) begin dbg0 = 5'(a); raddr0 = 10'($urandom); step(0); end

    // write held through the whole clear is dropped until RUN
    rst0 = 1'b1; wen0 = 1'b1; waddr0 = 5'd3; wdata0 = 64'h55; dbg0 = 5'd3; raddr0 = '0;
    step(0);
    rst0 = 1'b0;
    clr_wait(0, 32);
    chk("held_wen_r3_init", dbgd0, 64'h0);
    step(0);
    chk("held_wen_r3_after", dbgd0, 64'h55);
    wen0 = 1'b0;

    wen0 = 1'b1; waddr0 = 5'd6; wdata0 = 64'h0000_0000_DEAD_BEEF; raddr0 = {5'd6, 5'd6}; dbg0 = 5'd6;
    step(0);
    wen0 = 1'b0; #1;
    chk("r6_dbg", dbgd0, 64'hDEAD_BEEF);
    chk("r6_l0", rdata0[63:0], 64'hDEAD_BEEF);
    chk("r6_l1", rdata0[127:64], 64'hDEAD_BEEF);
    step(0);

    wen0 = 1'b1; waddr0 = 5'd0; wdata0 = '1; raddr0 = {5'd6, 5'd0}; dbg0 = 5'd0; #1;
    chk("x0_same", rdata0[63:0], 64'h0);
    step(0);
    wen0 = 1'b0; #1;
    chk("x0_next", rdata0[63:0], 64'h0);
    chk("x0_dbg", dbgd0, 64'h0);
    step(0);

    wen0 = 1'b1; waddr0 = 5'd5; wdata0 = 64'h11; step(0);
    wdata0 = 64'h22; raddr0 = {5'd5, 5'd0}; dbg0 = 5'd5; #1;
    chk("byp_l1", rdata0[127:64], 64'h22);
    chk("byp_dbg_old", dbgd0, 64'h11);
    step(0);
    wen0 = 1'b0; #1;
    chk("byp_dbg_new", dbgd0, 64'h22);
    chk("byp_l1_new", rdata0[127:64], 64'h22);
    step(0);

    // narrow build, no bypass
    step(1);
    rst1 = 1'b0;
    clr_wait(1, 16);
    wen1 = 1'b1; waddr1 = 4'd5; wdata1 = 32'h11; step(1);
    wdata1 = 32'h22; raddr1 = {4'd0, 4'd5, 4'd0}; dbg1 = 4'd5; #1;
    chk("nb_l1_old", 64'(rdata1[63:32]), 64'h11);
    step(1);
    wen1 = 1'b0; #1;
    chk("nb_l1_new", 64'(rdata1[63:32]), 64'h22);
    step(1);
    for (int i = 0; i < 300; i++) begin
      wen1 = 1'($urandom); waddr1 = 4'($urandom); wdata1 = $urandom;
      raddr1 = 12'($urandom); dbg1 = 4'($urandom);
      if (i % 4 == 0) raddr1[7:4] = waddr1;
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
